pulse_seq_ctrl: RTL and testbench
=================================

PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

Interface
REQ-001 Parameters SHALL be: CH, default 8, number of channels; W, default 12, pulse-width and count width; SETTLE, default 4, post-pulse settle cycles (legal range 1..15).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_ss  in  1  SPI-1 frame select, synchronous to clk; high = shifting
- i_start  in  1  software start pulse from the SPI-2 config register
- i_width  in  CH*W  packed pulse widths; channel k = bits [k*W +: W]
- i_sense  in  CH  per-channel sense inputs, synchronous to clk
- o_pulse  out  CH  per-channel drive pulses
- o_count  out  CH*W  latched per-channel counts, same packing as i_width
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle strobe on completion
- o_abort  out  1  one-cycle strobe on abort

Function
REQ-003 The block SHALL implement states IDLE, SETUP, PULSE, SETTLE, DONE, held in a registered state variable.
REQ-004 A registered copy ss_d of i_ss SHALL be kept; trigger = (ss_d==1 && i_ss==0) || i_start.
REQ-005 IDLE -> SETUP SHALL occur on the edge where trigger is true; trigger in any other state SHALL be ignored.
REQ-006 SETUP SHALL last exactly 1 cycle: capture i_width into an internal width register, clear all channel counters, clear timer, compute maxw = max over channels of captured width.
REQ-007 SETUP -> PULSE always; PULSE SHALL last max(maxw,1) cycles, timer counting 0 upward.
REQ-008 o_pulse[k] SHALL be registered and high exactly in PULSE cycles where timer < width_k: a pulse of width_k cycles starting the first PULSE cycle; width_k = 0 gives no pulse.
REQ-009 All channel pulses SHALL start on the same cycle; all maxw = 0 SHALL still give one PULSE cycle with o_pulse all-zero.
REQ-010 PULSE -> SETTLE after the last PULSE cycle; SETTLE SHALL last exactly SETTLE cycles with o_pulse all-zero.
REQ-011 In every PULSE and SETTLE cycle, channel counter k SHALL increment by 1 if i_sense[k]==1, saturating at 2^W-1 (4095), never wrapping.
REQ-012 SETTLE -> DONE; DONE SHALL last 1 cycle, copy all counters into o_count, assert o_done, then return to IDLE.
REQ-013 o_count SHALL change only in DONE (and reset); it holds its value through IDLE, aborts and later runs until the next DONE.
REQ-014 i_width changes after SETUP SHALL NOT affect the run in progress.
REQ-015 i_ss==1 sampled in SETUP, PULSE or SETTLE SHALL abort: next state IDLE, o_pulse forced 0 on that next cycle, o_abort high for 1 cycle, o_count unchanged, no o_done.
REQ-016 Abort and DONE SHALL be mutually exclusive; i_ss==1 in DONE SHALL NOT cancel DONE.
REQ-017 Total latency from trigger edge to o_done SHALL be 1 (SETUP) + max(maxw,1) + SETTLE + 1 cycles; with o_done counted as the DONE cycle, that is trigger edge + 2 + max(maxw,1) + SETTLE.
REQ-018 o_busy SHALL be registered-state-derived: high in SETUP, PULSE, SETTLE, DONE.

Reset
REQ-019 On rst_n low, asynchronously: state IDLE, ss_d 0, o_pulse 0, o_count 0, counters 0, timer 0, width register 0, o_busy 0, o_done 0, o_abort 0.
REQ-020 Reset asserted mid-run SHALL abandon the run without o_done or o_abort; after release the block SHALL be in IDLE awaiting a new trigger.

Verification
REQ-021 Widths ch0=3, ch1=0, ch7=10, others 1; i_ss falls -> SETUP next cycle; ch0 high 3 cycles, ch1 never, ch7 10 cycles, all aligned; o_done 2+10+4 = 16 cycles after the trigger edge.
REQ-022 i_sense[2] tied high, maxw=5, SETTLE=4 -> o_count ch2 = 9, other channels 0 with sense low.
REQ-023 i_sense[0] high, ch0 width 4095 -> PULSE 4095 + SETTLE 4 cycles; ch0 count saturates at 4095.
REQ-024 i_ss rises during PULSE timer=2 -> o_pulse 0 next cycle, o_abort 1 cycle, o_count keeps previous run's value, state IDLE.
REQ-025 i_start pulse while busy -> ignored, run length unchanged; all widths 0 with i_start -> o_done 2+1+4 = 7 cycles after trigger, o_count all 0.
REQ-026 rst_n low during SETTLE -> all outputs 0 immediately; after release a fresh i_ss falling edge runs normally.

Source files
------------

// File: rtl/pulse_seq_ctrl.sv
// Multi-channel pulse sequencer: one trigger fires aligned per-channel pulses, then a settle window.
// Per-channel sense counts accumulate over pulse+settle and are published on completion.
module pulse_seq_ctrl #(
    parameter int CH     = 8,
    parameter int W      = 12,
    parameter int SETTLE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_ss,
    input  logic            i_start,
    input  logic [CH*W-1:0] i_width,
    input  logic [CH-1:0]   i_sense,
    output logic [CH-1:0]   o_pulse,
    output logic [CH*W-1:0] o_count,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_abort
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam logic [W-1:0] SETTLE_LAST = W'(SETTLE - 1);
    localparam logic [W-1:0] ONE         = W'(1);

    state_t       r_state;
    state_t       w_state_next;
    logic         r_ss_d;
    logic         w_trigger;
    logic         w_abort;
    logic [W-1:0] r_timer;
    logic [W-1:0] r_pulse_last;
    logic [W-1:0] w_maxw;
    logic [W-1:0] r_width [CH];
    logic [W-1:0] r_cnt   [CH];
    logic [W-1:0] r_out   [CH];
    logic         r_pulse [CH];
    logic         r_done;
    logic         r_abort;

    assign w_trigger = (r_ss_d && !i_ss) || i_start;

    always_comb begin
        w_maxw = '0;
        for (int k = 0; k < CH; k++) begin
            if (i_width[k*W +: W] > w_maxw) begin
                w_maxw = i_width[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_PULSE;
            end
            ST_PULSE: begin
                if (r_timer == r_pulse_last) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_timer == SETTLE_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Frame select reasserted mid-run cancels it; DONE is already committed.
        if (i_ss && (r_state == ST_SETUP || r_state == ST_PULSE || r_state == ST_SETTLE)) begin
            w_abort      = 1'b1;
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_d       <= 1'b0;
            r_timer      <= '0;
            r_pulse_last <= '0;
            r_done       <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_ss_d  <= i_ss;
            r_done  <= (r_state == ST_DONE);
            r_abort <= w_abort;
            case (r_state)
                ST_PULSE:  r_timer <= (r_timer == r_pulse_last) ? '0 : r_timer + ONE;
                ST_SETTLE: r_timer <= r_timer + ONE;
                default:   r_timer <= '0;
            endcase
            // All-zero widths still need one PULSE cycle, so the last index floors at 0.
            if (r_state == ST_SETUP) begin
                r_pulse_last <= (w_maxw == '0) ? '0 : w_maxw - ONE;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_width[gi] <= '0;
                    r_cnt[gi]   <= '0;
                    r_out[gi]   <= '0;
                    r_pulse[gi] <= 1'b0;
                end else begin
                    r_pulse[gi] <= (r_state == ST_PULSE) && !w_abort && (r_timer < r_width[gi]);
                    if (r_state == ST_SETUP) begin
                        r_width[gi] <= i_width[gi*W +: W];
                        r_cnt[gi]   <= '0;
                    end else if ((r_state == ST_PULSE || r_state == ST_SETTLE)
                                 && i_sense[gi] && (r_cnt[gi] != '1)) begin
                        r_cnt[gi] <= r_cnt[gi] + ONE;
                    end
                    if (r_state == ST_DONE) begin
                        r_out[gi] <= r_cnt[gi];
                    end
                end
            end

            assign o_pulse[gi]        = r_pulse[gi];
            assign o_count[gi*W +: W] = r_out[gi];
        end
    endgenerate

    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = r_done;
    assign o_abort = r_abort;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl: cycle numbers are edges counted after the trigger edge (E0).
module tb_pulse_seq_ctrl;

    localparam int CH     = 8;
    localparam int W      = 12;
    localparam int SETTLE = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_ss = 1'b0;
    logic            i_start = 1'b0;
    logic [CH*W-1:0] i_width = '0;
    logic [CH-1:0]   i_sense = '0;
    logic [CH-1:0]   o_pulse;
    logic [CH*W-1:0] o_count;
    logic            o_busy;
    logic            o_done;
    logic            o_abort;

    pulse_seq_ctrl #(.CH(CH), .W(W), .SETTLE(SETTLE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ss    (i_ss),
        .i_start (i_start),
        .i_width (i_width),
        .i_sense (i_sense),
        .o_pulse (o_pulse),
        .o_count (o_count),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_abort (o_abort)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int pulse_cnt   [CH];
    int pulse_first [CH];
    int pulse_total;
    int done_edge, done_cnt, abort_edge, abort_cnt;
    logic [CH-1:0]   pulse_hist [32];
    logic [CH*W-1:0] cnt_hist   [32];
    logic [CH*W-1:0] exp_cnt;
    logic [CH*W-1:0] prev_cnt;

    task automatic check(input string tag, input logic [CH*W-1:0] obs, input logic [CH*W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trig_ss();
        i_ss = 1'b1;
        tick();
        i_ss = 1'b0;
        tick();
    endtask

    task automatic trig_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Runs n edges after E0, recording outputs; optional start pulse, ss rise and width change.
    task automatic collect(input int n, input int start_at, input int ss_at,
                           input int alt_at, input logic [CH*W-1:0] alt_w);
        for (int k = 0; k < CH; k++) begin
            pulse_cnt[k]   = 0;
            pulse_first[k] = -1;
        end
        pulse_total = 0;
        done_edge   = -1;
        done_cnt    = 0;
        abort_edge  = -1;
        abort_cnt   = 0;
        for (int c = 1; c <= n; c++) begin
            tick();
            for (int k = 0; k < CH; k++) begin
                if (o_pulse[k]) begin
                    pulse_cnt[k]++;
                    pulse_total++;
                    if (pulse_first[k] < 0) pulse_first[k] = c;
                end
            end
            if (o_done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = c;
            end
            if (o_abort) begin
                abort_cnt++;
                if (abort_edge < 0) abort_edge = c;
            end
            if (c < 32) begin
                pulse_hist[c] = o_pulse;
                cnt_hist[c]   = o_count;
            end
            i_start = (c == start_at);
            if (ss_at >= 0 && c >= ss_at) i_ss = 1'b1;
            if (c == alt_at) i_width = alt_w;
        end
        i_start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy",  o_busy,  0);
        check("rst_pulse", o_pulse, 0);
        check("rst_count", o_count, 0);
        check("rst_done",  o_done,  0);
        check("rst_abort", o_abort, 0);
        rst_n = 1'b1;
        tick();

        // Mixed widths, late i_start ignored, width change after SETUP ignored
        for (int k = 0; k < CH; k++) i_width[k*W +: W] = 12'd1;
        i_width[0*W +: W] = 12'd3;
        i_width[1*W +: W] = 12'd0;
        i_width[7*W +: W] = 12'd10;
        i_sense = '0;
        trig_ss();
        check("a_setup_busy",  o_busy,  1);
        check("a_setup_pulse", o_pulse, 0);
        collect(24, 5, -1, 2, '0);
        check("a_ch0_len",   pulse_cnt[0], 3);
        check("a_ch1_len",   pulse_cnt[1], 0);
        check("a_ch3_len",   pulse_cnt[3], 1);
        check("a_ch7_len",   pulse_cnt[7], 10);
        check("a_ch0_first", pulse_first[0], 2);
        check("a_ch3_first", pulse_first[3], 2);
        check("a_ch7_first", pulse_first[7], 2);
        check("a_done_edge", done_edge, 16);
        check("a_done_cnt",  done_cnt, 1);
        check("a_abort_cnt", abort_cnt, 0);
        check("a_count",     o_count, 0);
        check("a_idle_busy", o_busy, 0);

        // Sense on ch2, maxw 5, i_start trigger
        for (int k = 0; k < CH; k++) i_width[k*W +: W] = 12'd2;
        i_width[2*W +: W] = 12'd5;
        i_sense = 8'b0000_0100;
        trig_start();
        collect(16, -1, -1, -1, '0);
        exp_cnt = '0;
        exp_cnt[2*W +: W] = 12'd9;
        check("b_done_edge", done_edge, 11);
        check("b_count",     o_count, exp_cnt);
        check("b_ch2_len",   pulse_cnt[2], 5);
        check("b_ch0_len",   pulse_cnt[0], 2);
        prev_cnt = exp_cnt;

        // Abort: i_ss rises while timer = 2
        for (int k = 0; k < CH; k++) i_width[k*W +: W] = 12'd6;
        i_sense = '1;
        trig_ss();
        collect(10, -1, 3, -1, '0);
        check("c_pulse_pre",  pulse_hist[3], 8'hFF);
        check("c_pulse_post", pulse_hist[4], 8'h00);
        check("c_abort_edge", abort_edge, 4);
        check("c_abort_cnt",  abort_cnt, 1);
        check("c_done_cnt",   done_cnt, 0);
        check("c_count_kept", o_count, prev_cnt);
        check("c_idle_busy",  o_busy, 0);

        // i_ss falls (new run), reset asserted during SETTLE
        for (int k = 0; k < CH; k++) i_width[k*W +: W] = 12'd2;
        i_ss = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) tick();
        check("d_settle_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check("d_rst_busy",  o_busy,  0);
        check("d_rst_pulse", o_pulse, 0);
        check("d_rst_count", o_count, 0);
        check("d_rst_done",  o_done,  0);
        check("d_rst_abort", o_abort, 0);
        tick();
        tick();
        rst_n = 1'b1;
        collect(10, -1, -1, -1, '0);
        check("d_post_done",  done_cnt, 0);
        check("d_post_abort", abort_cnt, 0);
        check("d_post_pulse", pulse_total, 0);
        check("d_post_busy",  o_busy, 0);

        // All widths zero via i_start
        i_width = '0;
        i_sense = '0;
        trig_start();
        collect(10, -1, -1, -1, '0);
        check("e_done_edge", done_edge, 7);
        check("e_done_cnt",  done_cnt, 1);
        check("e_pulses",    pulse_total, 0);
        check("e_count",     o_count, 0);

        // Fresh i_ss falling run after reset; width change mid-run ignored
        for (int k = 0; k < CH; k++) i_width[k*W +: W] = W'(k);
        i_sense = 8'b0000_0001;
        trig_ss();
        collect(16, -1, -1, 2, '1);
        exp_cnt = '0;
        exp_cnt[0*W +: W] = 12'd11;
        check("f_done_edge",  done_edge, 13);
        check("f_count_hold", cnt_hist[12], 0);
        check("f_count",      o_count, exp_cnt);
        check("f_ch5_len",    pulse_cnt[5], 5);
        check("f_ch0_len",    pulse_cnt[0], 0);
        check("f_ch7_first",  pulse_first[7], 2);

        // Saturation: ch0 width 4095 with sense high
        i_width = '0;
        i_width[0*W +: W] = 12'd4095;
        trig_start();
        collect(4106, -1, -1, -1, '0);
        exp_cnt = '0;
        exp_cnt[0*W +: W] = 12'hFFF;
        check("g_done_edge", done_edge, 4101);
        check("g_ch0_len",   pulse_cnt[0], 4095);
        check("g_count_sat", o_count, exp_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
